// File: rtl/matrix_operand_loader_if.sv
// Stream-in / operands-out bundle between the element source, the loader and the matrix adder.
`timescale 1ns/1ps
interface matrix_operand_loader_if #(
  parameter int ELEM_W  = 8,
  parameter int MAX_DIM = 5
);
  localparam int PW = ELEM_W * MAX_DIM * MAX_DIM;

  logic              start;
  logic [1:0]        size_in;
  logic              in_valid;
  logic [ELEM_W-1:0] in_data;
  logic              in_ready;
  logic              out_ready;
  logic              operands_valid;
  logic [PW-1:0]     matrix_A;
  logic [PW-1:0]     matrix_B;
  logic [1:0]        matrix_size;
  logic              busy;
  logic              protocol_err;

  modport master (
    output start, size_in, in_valid, in_data, out_ready,
    input  in_ready, operands_valid, matrix_A, matrix_B, matrix_size, busy, protocol_err
  );
  modport slave (
    input  start, size_in, in_valid, in_data, out_ready,
    output in_ready, operands_valid, matrix_A, matrix_B, matrix_size, busy, protocol_err
  );
endinterface

// File: rtl/matrix_operand_loader.sv
// Assembles operand matrices A then B from a one-element-per-beat stream and holds them for the adder.
`timescale 1ns/1ps
module matrix_operand_loader #(
  parameter int ELEM_W  = 8,
  parameter int MAX_DIM = 5
) (
  input  logic clk,
  input  logic rst_n,
  matrix_operand_loader_if.slave bus
);
  localparam int NE = MAX_DIM * MAX_DIM;

  typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, HOLD} state_t;

  state_t                       state;
  logic [4:0]                   count;
  logic [4:0]                   last;
  logic [1:0]                   size_q;
  logic [NE-1:0][ELEM_W-1:0]    mat_a;
  logic [NE-1:0][ELEM_W-1:0]    mat_b;
  logic                         in_ready_q;
  logic                         ovalid_q;
  logic                         busy_q;
  logic                         perr_q;
  logic                         beat;

  // Index of the final element for the latched size: N*N-1.
  always_comb begin
    last = 5'd3;
    case (size_q)
      2'b00: last = 5'd3;
      2'b01: last = 5'd8;
      2'b10: last = 5'd15;
      2'b11: last = 5'd24;
    endcase
  end

  assign beat = bus.in_valid && in_ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      size_q     <= 2'b00;
      mat_a      <= '0;
      mat_b      <= '0;
      in_ready_q <= 1'b0;
      ovalid_q   <= 1'b0;
      busy_q     <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      perr_q <= bus.start && (state != IDLE);
      case (state)
        IDLE: if (bus.start) begin
          size_q     <= bus.size_in;
          mat_a      <= '0;
          mat_b      <= '0;
          count      <= '0;
          state      <= LOAD_A;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b1;
        end
        LOAD_A: if (beat) begin
          mat_a[count] <= bus.in_data;
          if (count == last) begin
            count <= '0;
            state <= LOAD_B;
          end else begin
            count <= count + 5'd1;
          end
        end
        LOAD_B: if (beat) begin
          mat_b[count] <= bus.in_data;
          if (count == last) begin
            state      <= HOLD;
            in_ready_q <= 1'b0;
            ovalid_q   <= 1'b1;
          end else begin
            count <= count + 5'd1;
          end
        end
        HOLD: if (bus.out_ready) begin
          state    <= IDLE;
          ovalid_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready       = in_ready_q;
  assign bus.operands_valid = ovalid_q;
  assign bus.busy           = busy_q;
  assign bus.protocol_err   = perr_q;
  assign bus.matrix_size    = size_q;
  assign bus.matrix_A       = mat_a;
  assign bus.matrix_B       = mat_b;
endmodule

// File: doc/matrix_operand_loader.md
# matrix_operand_loader

Sequential front end for the combinational matrix adder. Accepts signed 8-bit elements one per beat over a valid/ready stream, assembles operand matrices A then B in the packed row-major 200-bit format, and presents them with the size code under an output valid/ready handshake. Its outputs drive `matrix_A`, `matrix_B` and `matrix_size` of the adder directly.

## Interface
- `ELEM_W`, 8: element width in bits, two's complement.
- `MAX_DIM`, 5: largest supported dimension; packed width is `ELEM_W*MAX_DIM*MAX_DIM` = 200.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: begin a load; honoured only in IDLE.
- `size_in`  in  2: size code, sampled with `start`. 00=2x2, 01=3x3, 10=4x4, 11=5x5.
- `in_valid`  in  1: `in_data` holds an element.
- `in_data`  in  8: signed element.
- `in_ready`  out  1: loader accepts an element this cycle.
- `out_ready`  in  1: consumer has taken the operands.
- `operands_valid`  out  1: A, B and size are complete and stable.
- `matrix_A`  out  200: packed operand A; element i at `[i*8 +: 8]`.
- `matrix_B`  out  200: packed operand B, same layout.
- `matrix_size`  out  2: latched size code.
- `busy`  out  1: state is not IDLE.
- `protocol_err`  out  1: one-cycle pulse when `start` is ignored.

## Operation
- FSM states: IDLE, LOAD_A, LOAD_B, HOLD.
- IDLE + `start`:
  - latch `size_in` into `matrix_size`;
  - clear `matrix_A` and `matrix_B` to 0;
  - clear the element counter;
  - go to LOAD_A.
- N = size code + 2. Total elements per matrix T = N*N (4, 9, 16 or 25).
- Beat: `in_valid && in_ready`. The element is written to index `count` of the current matrix, in row-major order. Index i = row*N + col.
- Counter is 5 bits.
  - LOAD_A: on the beat with `count == T-1`, reset the counter and go to LOAD_B.
  - LOAD_B: on the beat with `count == T-1`, go to HOLD.
- Elements at indices T..24 remain 0 for the whole transaction.
- HOLD: `operands_valid` = 1. When `out_ready` = 1, go to IDLE.
- After leaving HOLD, `matrix_A`, `matrix_B` and `matrix_size` retain their values until the next accepted `start`.
- `start` in any state other than IDLE:
  - ignored;
  - `protocol_err` pulses high for one cycle;
  - state, counter and matrices are unaffected.
- No arithmetic is performed here. Elements are stored bit-exact; no sign extension is needed.

## Timing
- Reset values, applied immediately on `rst_n` low, independent of `clk`:
  - state IDLE, counter 0;
  - `in_ready` 0, `operands_valid` 0, `busy` 0, `protocol_err` 0;
  - `matrix_A` 0, `matrix_B` 0, `matrix_size` 2'b00.
- Reset mid-transaction discards all partial data.
- `in_ready` and `operands_valid` are registered state decodes; neither depends combinationally on any input.
  - `in_ready` = 1 exactly in LOAD_A and LOAD_B.
  - `operands_valid` = 1 exactly in HOLD.
- `start` sampled at edge k:
  - LOAD_A from cycle k+1, so `in_ready` is high from cycle k+1;
  - with `in_valid` held high, the last B beat is at cycle k+2T;
  - `operands_valid` rises at cycle k+2T+1.
- Minimum start-to-valid latency is 2T+1 cycles. Each cycle with `in_valid` low adds one cycle.
- No element is lost or duplicated across the A to B boundary. The first B element may arrive in the cycle right after the last A element.
- `in_data` is ignored when `in_valid` = 0 or `in_ready` = 0.
- Handshake on the output side:
  - `out_ready` seen in HOLD at edge m: IDLE from m+1, and `operands_valid` falls at m+1.
  - `out_ready` while not in HOLD is ignored.
  - Operand outputs are constant for as long as `operands_valid` = 1.
- `start` at the same edge that leaves HOLD is ignored (state is not IDLE) and pulses `protocol_err`.
- `busy` = 1 in LOAD_A, LOAD_B and HOLD.

## Test plan
- Reset: assert `rst_n`=0 mid-clock -> all outputs 0 before the next edge; `matrix_size` 2'b00.
- 2x2 load: `start` with `size_in`=00, A = 1,2,3,4 and B = -1,-2,-3,-4 with `in_valid` held high -> `in_ready` high for 8 cycles, `operands_valid` high 9 cycles after `start`. Check `matrix_A[31:0]`=32'h04030201, `matrix_B[31:0]`=32'hFCFDFEFF, and bits [199:32] of both = 0.
- 5x5 load with stalls: size 11, A = -90,-80,-70,-60,-50,-40,-30,-20,-10,-1,120,110,100,90,80,70,60,40,30,20,3,5,10,50,127 and B = 10,9,8,7,6,5,4,3,2,1,10,20,20,10,10,50,40,30,20,10,5,10,20,60,1, with `in_valid` low every third cycle -> `matrix_A[7:0]`=8'hA6, `matrix_A[199:192]`=8'h7F, `matrix_B[199:192]`=8'h01, every field matches, `operands_valid` only after 50 beats.
- Protocol error: `start` pulsed during LOAD_A after 2 beats -> `protocol_err` high for exactly one cycle; load completes normally with 2T beats total.
- Hold/backpressure: `out_ready` low for 10 cycles in HOLD -> outputs stable and `in_ready` 0. Then `out_ready`=1 for one cycle -> next cycle IDLE, `operands_valid` 0, matrices unchanged.
- Reset in LOAD_B after 3 B beats -> immediate return to all-zero outputs. A following 3x3 load completes correctly with indices 9..24 = 0.
